// File: rtl/rv32v_element_sequencer.sv
// Two-lane vector element sequencer: walks vstart..vl-1 two elements per beat
// and derives per-lane register/byte offsets for the execute datapath.
module rv32v_element_sequencer #(
  parameter int VLEN = 128,
  parameter int IW   = $clog2(VLEN)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [31:0]                 vl,
  input  logic [31:0]                 vstart,
  input  logic [1:0]                  sew,
  input  logic                        vd_widen,
  input  logic                        stall,
  input  logic                        flush,
  output logic                        ready,
  output logic                        valid,
  output logic [IW-1:0]               elem0,
  output logic [IW-1:0]               elem1,
  output logic                        ena0,
  output logic                        ena1,
  output logic [2:0]                  src_reg0,
  output logic [2:0]                  src_reg1,
  output logic [$clog2(VLEN/8)-1:0]   src_byte0,
  output logic [$clog2(VLEN/8)-1:0]   src_byte1,
  output logic [2:0]                  dst_reg0,
  output logic [2:0]                  dst_reg1,
  output logic                        counter_done,
  output logic                        decode_done,
  output logic                        vill_err
);

  localparam int VLENB = VLEN / 8;
  localparam int LB    = $clog2(VLENB);
  // two spare bits so cnt+2 past the last element never wraps
  localparam int CW    = IW + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] vl_r;
  logic [1:0]    sew_r;
  logic          widen_r;
  logic          ill;

  logic [CW-1:0] vl_clamp;
  logic          start_ill;
  logic          start_empty;
  logic [CW-1:0] cnt_p1;
  logic [CW-1:0] cnt_p2;
  logic          last_beat;
  logic [3:0]    src_sh;
  logic [3:0]    dst_sh;

  // Start-time qualification of the incoming instruction
  always_comb begin
    vl_clamp    = (vl > 32'(VLEN)) ? CW'(VLEN) : vl[CW-1:0];
    start_ill   = (sew == 2'd3) || (vd_widen && (sew == 2'd2));
    start_empty = vstart >= 32'(vl_clamp);
  end

  // Beat bookkeeping derived from the element counter
  always_comb begin
    cnt_p1    = cnt + CW'(1);
    cnt_p2    = cnt + CW'(2);
    last_beat = cnt_p2 >= vl_r;
    src_sh    = 4'(LB) - {2'b00, sew_r};
    dst_sh    = src_sh - {3'b000, widen_r};
  end

  // Sequencer FSM with instruction latches and element counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      vl_r    <= '0;
      sew_r   <= '0;
      widen_r <= 1'b0;
      ill     <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vl_r    <= vl_clamp;
            cnt     <= vstart[CW-1:0];
            sew_r   <= sew;
            widen_r <= vd_widen;
            ill     <= start_ill;
            state   <= (start_ill || start_empty) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            cnt <= cnt_p2;
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [2:0] reg_of(
    input logic [IW-1:0] e,
    input logic [3:0]    sh
  );
    logic [IW-1:0] t;
    t = e >> sh;
    return t[2:0];
  endfunction

  function automatic logic [LB-1:0] byte_of(
    input logic [IW-1:0] e,
    input logic [1:0]    s
  );
    logic [IW+1:0] t;
    t = {2'b00, e} << s;
    return t[LB-1:0];
  endfunction

  // Lane outputs, all decoded from registers and zeroed outside RUN
  always_comb begin
    ready        = state == IDLE;
    valid        = state == RUN;
    decode_done  = state == DONE;
    vill_err     = decode_done && ill;
    elem0        = valid ? cnt[IW-1:0] : '0;
    elem1        = valid ? cnt_p1[IW-1:0] : '0;
    ena0         = valid && (cnt < vl_r);
    ena1         = valid && (cnt_p1 < vl_r);
    counter_done = valid && last_beat;
    src_reg0     = reg_of(elem0, src_sh);
    src_reg1     = reg_of(elem1, src_sh);
    src_byte0    = byte_of(elem0, sew_r);
    src_byte1    = byte_of(elem1, sew_r);
    dst_reg0     = reg_of(elem0, dst_sh);
    dst_reg1     = reg_of(elem1, dst_sh);
  end

endmodule

// File: tb/tb_rv32v_element_sequencer.sv
// Directed and randomized bench for rv32v_element_sequencer against a
// byte-address reference model of the element walk.
module tb_rv32v_element_sequencer;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [31:0] vl;
  logic [31:0] vstart;
  logic [1:0]  sew;
  logic        vd_widen;
  logic        stall;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [6:0]  elem0;
  logic [6:0]  elem1;
  logic        ena0;
  logic        ena1;
  logic [2:0]  src_reg0;
  logic [2:0]  src_reg1;
  logic [3:0]  src_byte0;
  logic [3:0]  src_byte1;
  logic [2:0]  dst_reg0;
  logic [2:0]  dst_reg1;
  logic        counter_done;
  logic        decode_done;
  logic        vill_err;

  int checks = 0;
  int errors = 0;

  rv32v_element_sequencer #(.VLEN(128)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .vl(vl),
    .vstart(vstart),
    .sew(sew),
    .vd_widen(vd_widen),
    .stall(stall),
    .flush(flush),
    .ready(ready),
    .valid(valid),
    .elem0(elem0),
    .elem1(elem1),
    .ena0(ena0),
    .ena1(ena1),
    .src_reg0(src_reg0),
    .src_reg1(src_reg1),
    .src_byte0(src_byte0),
    .src_byte1(src_byte1),
    .dst_reg0(dst_reg0),
    .dst_reg1(dst_reg1),
    .counter_done(counter_done),
    .decode_done(decode_done),
    .vill_err(vill_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_word(
    input logic v, input int e0, input int e1, input logic en0,
    input logic en1, input logic cd, input logic dd, input logic rdy);
    return 32'({v, 7'(e0), 7'(e1), en0, en1, cd, dd, rdy});
  endfunction

  function automatic logic [31:0] ctl_obs();
    return ctl_word(valid, int'(elem0), int'(elem1), ena0, ena1,
                    counter_done, decode_done, ready);
  endfunction

  function automatic logic [31:0] off_obs();
    return 32'({src_reg0, src_byte0, dst_reg0,
                src_reg1, src_byte1, dst_reg1});
  endfunction

  // element index -> byte address within the register group
  function automatic logic [9:0] lane_off(input int e, input int s,
                                          input int w);
    int ba;
    int sreg;
    int sbyte;
    int dreg;
    ba    = e * (1 << s);
    sreg  = (ba / 16) % 8;
    sbyte = ba % 16;
    dreg  = ((ba * (w != 0 ? 2 : 1)) / 16) % 8;
    return {3'(sreg), 4'(sbyte), 3'(dreg)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat_chk(input int e, input int vlr, input int s,
                          input int w);
    int e0;
    int e1;
    e0 = e % 128;
    e1 = (e + 1) % 128;
    chk("beat_ctl", ctl_obs(),
        ctl_word(1'b1, e0, e1, e < vlr, e + 1 < vlr, e + 2 >= vlr,
                 1'b0, 1'b0));
    chk("beat_off", off_obs(),
        32'({lane_off(e0, s, w), lane_off(e1, s, w)}));
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, ctl_obs(), ctl_word(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // one full instruction; beat index sb is stalled for sn cycles
  task automatic run(input int v, input int vs, input int s, input int w,
                     input int sb, input int sn);
    int  vlr;
    int  nb;
    bit  il;
    vlr = (v > 128) ? 128 : v;
    il  = (s == 3) || (w != 0 && s == 2);
    nb  = (il || vs >= vlr) ? 0 : (vlr - vs + 1) / 2;
    idle_chk("pre_start");
    start    = 1'b1;
    vl       = 32'(v);
    vstart   = 32'(vs);
    sew      = 2'(s);
    vd_widen = w != 0;
    tick();
    start  = 1'b0;
    vl     = $urandom;
    vstart = $urandom;
    for (int b = 0; b < nb; b++) begin
      if (b == sb) begin
        for (int k = 0; k < sn; k++) begin
          stall = 1'b1;
          beat_chk(vs + 2 * b, vlr, s, w);
          tick();
        end
      end
      stall = 1'b0;
      beat_chk(vs + 2 * b, vlr, s, w);
      tick();
    end
    chk("done_ctl", ctl_obs(),
        ctl_word(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("vill", 32'(vill_err), 32'(il));
    tick();
    idle_chk("post_done");
    chk("vill_idle", 32'(vill_err), 32'd0);
  endtask

  initial begin
    RST      = 1'b1;
    start    = 1'b0;
    vl       = '0;
    vstart   = '0;
    sew      = '0;
    vd_widen = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    #3;
    idle_chk("reset_ctl");
    chk("reset_off", off_obs(), 32'd0);
    chk("reset_vill", 32'(vill_err), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b0;
    tick();

    run(5, 0, 2, 0, -1, 0);
    run(40, 17, 0, 1, -1, 0);
    run(6, 0, 2, 0, 1, 3);
    run(8, 8, 1, 0, -1, 0);
    run(5, 0, 3, 0, -1, 0);
    run(7, 0, 2, 1, -1, 0);
    run(200, 0, 0, 0, 5, 2);
    run(128, 1, 1, 1, 63, 1);

    start  = 1'b1;
    vl     = 32'd10;
    vstart = 32'd0;
    sew    = 2'd1;
    tick();
    start = 1'b0;
    beat_chk(0, 10, 1, 0);
    tick();
    beat_chk(2, 10, 1, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_chk("after_flush");
    run(4, 1, 0, 0, -1, 0);

    start  = 1'b1;
    vl     = 32'd20;
    vstart = 32'd0;
    sew    = 2'd0;
    tick();
    start = 1'b0;
    beat_chk(0, 20, 0, 0);
    tick();
    beat_chk(2, 20, 0, 0);
    #2 RST = 1'b1;
    #1;
    idle_chk("async_rst_ctl");
    chk("async_rst_off", off_obs(), 32'd0);
    chk("async_rst_vill", 32'(vill_err), 32'd0);
    @(posedge CLK);
    #1;
    idle_chk("rst_hold");
    #2 RST = 1'b0;
    tick();
    run(2, 0, 2, 0, -1, 0);

    for (int i = 0; i < 30; i++) begin
      int v;
      int vs;
      v  = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 140));
      vs = int'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) vs = v + int'($urandom_range(0, 3));
      run(v, vs, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32v_element_sequencer.md
# rv32v_element_sequencer

Issue-side controller for the two-lane vector execute datapath. It accepts one decoded vector instruction at a time and steps through its active element range, two elements per beat. For each lane it produces the element index, the lane enable, and the source and destination register-group and byte offsets. It drives the per-beat woffset, counter_done and decode_done control of the decode→execute path, honouring execute back-pressure and pipeline flush.

## Interface
Parameters:
- VLEN, 128, vector register length in bits; VLENB = VLEN/8, LB = $clog2(VLENB)
- IW, $clog2(VLEN), element-index width (max elements = VLEN at LMUL=8, SEW=8)

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- start  in  1  decoded vector instruction present; accepted only when ready=1
- vl  in  32  vector length; values > VLEN are clamped to VLEN
- vstart  in  32  first active element
- sew  in  2  0=8b, 1=16b, 2=32b, 3=reserved
- vd_widen  in  1  destination EEW = 2×SEW
- stall  in  1  execute cannot accept the current beat
- flush  in  1  abort the current instruction
- ready  out  1  sequencer idle, able to accept start
- valid  out  1  beat outputs meaningful
- elem0, elem1  out  IW  element indices for lane 0 / lane 1
- ena0, ena1  out  1  lane element < vl
- src_reg0, src_reg1  out  3  register offset within source group
- src_byte0, src_byte1  out  LB  byte offset within source register
- dst_reg0, dst_reg1  out  3  register offset within destination group
- counter_done  out  1  current beat is the last beat
- decode_done  out  1  one-cycle pulse, instruction fully issued
- vill_err  out  1  valid only with decode_done; the instruction was illegal

## Operation
- States: IDLE, RUN, DONE. Reset and flush both go to IDLE.
- In IDLE, ready=1. When start=1:
  - Latch vl_r = min(vl, VLEN), cnt = vstart, sew_r and widen_r.
  - Set ill = (sew==3) or (vd_widen and sew==2).
  - If ill or vstart ≥ vl_r, go to DONE with no beats. Otherwise go to RUN.
- In RUN:
  - valid=1, elem0=cnt, elem1=cnt+1.
  - ena0 = cnt<vl_r; ena1 = cnt+1<vl_r.
  - counter_done = cnt+2 ≥ vl_r.
- Beat acceptance: a beat is accepted when valid and !stall.
  - On accept, cnt += 2.
  - If counter_done, go to DONE.
  - When stall=1, hold cnt and all outputs.
- DONE: decode_done=1 and vill_err=ill for exactly one cycle, then go to IDLE.
- Offset arithmetic for each lane with index e (upper bits are dropped to the stated width):
  - src_reg = e >> (LB − sew)
  - src_byte = (e << sew) mod VLENB
  - dst_reg = e >> (LB − sew − widen)
- flush has priority over start, stall and the state transitions. The next cycle is IDLE with valid=0 and no decode_done pulse.
- start is ignored when ready=0.

## Timing
- Reset values of outputs: ready=1; all other outputs 0. Internal registers (cnt, vl_r, sew_r, widen_r, ill) are cleared to 0.
- All state, counter and latch registers update on the rising edge of CLK. Outputs are combinational from registers only, with no combinational path from the inputs.
- Latency: start accepted at edge N → first beat valid in cycle N+1.
- With no stalls, beats = ceil((vl_r−vstart)/2). decode_done appears the cycle after the last accepted beat.
- Zero-beat case (vstart ≥ vl_r, or ill): decode_done in cycle N+1, and ready returns in cycle N+2.
- Back-to-back: the next start is accepted in the first IDLE cycle after DONE. There is 1 bubble cycle between instructions.
- Odd element count: the last beat has ena1=0, and elem1 still equals cnt+1.
- RST asserted mid-RUN: outputs return to their reset values immediately (asynchronously), with no done pulse.

## Test plan
- VLEN=128, vl=5, vstart=0, sew=2, no stall:
  - Beats (0,1), (2,3), (4,5) in cycles 1–3; the third beat has ena1=0 and counter_done=1.
  - elem4 gives src_reg=1, src_byte=0; elem3 gives src_byte=12.
  - decode_done in cycle 4.
- sew=0, vl=40, vstart=17, vd_widen=1:
  - First beat is elements (17,18) with src_reg=1, src_byte=1,2 and dst_reg=2,2.
  - 12 beats total; the last beat is (39,40) with ena1=0.
- stall held for 3 cycles on beat 2 of vl=6: beat (2,3) is held stable for 3 cycles; total issue takes 6 cycles and decode_done comes in cycle 7.
- vstart=8, vl=8; separately sew=3; separately vl=200 → clamped to 128:
  - First two cases: decode_done in cycle 1, no valid beats; vill_err=0 and 1 respectively.
  - Clamped case: 64 beats.
- flush asserted during beat 2 of vl=10: the next cycle has valid=0 and ready=1, and no decode_done pulse occurs. A start in that cycle is accepted normally.
- RST pulse mid-RUN, asynchronous to CLK: outputs go to reset values without waiting for an edge. After release, start with vl=2 gives a single beat (0,1) with counter_done=1.
